// File: rtl/stepper_axis_ctrl_if.sv
// Command channel of one stepper axis: move request handshake plus abort.
interface stepper_axis_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [DIV_W-1:0] cmd_period;
    logic [1:0]       cmd_mode;
    logic             abort;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_period, cmd_mode, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_period, cmd_mode, abort,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_axis_ctrl.sv
// Single-axis stepper sequencer: accepts a move, ramps the step period linearly
// up/down around a cruise target and drives the 4 coil lines in wave/full/half mode.
module stepper_axis_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DIV_W        = 24,
    parameter int POS_W        = 16,
    parameter int START_PERIOD = 50000,
    parameter int RAMP_DEC     = 2000,
    parameter int MIN_PERIOD   = 2,
    parameter bit HOLD_EN      = 1'b1
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    stepper_axis_ctrl_if.slave  cmd,
    output logic [3:0]          phase,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [POS_W-1:0]    position,
    output logic [CNT_W-1:0]    steps_left
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef logic [DIV_W:0] ext_t;

    localparam ext_t START_X = ext_t'(START_PERIOD);
    localparam ext_t DEC_X   = ext_t'(RAMP_DEC);
    localparam ext_t MIN_X   = ext_t'(MIN_PERIOD);
    localparam logic [DIV_W-1:0] ONE_P   = 1;
    localparam logic [CNT_W-1:0] ONE_C   = 1;
    localparam logic [CNT_W-1:0] ZERO_C  = '0;
    localparam logic [POS_W-1:0] ONE_POS = 1;

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic [CNT_W-1:0] sl_nxt, sl_dec;
    logic             done_nxt, aborted_nxt;
    logic             dir_q, dir_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [DIV_W-1:0] target, target_nxt;
    logic [DIV_W-1:0] cur_p, cur_p_nxt;
    logic [DIV_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] ramp_cnt, ramp_nxt;

    // Ramp arithmetic one bit wider than a period so neither direction wraps.
    ext_t tgt_in_x, start_x, cur_x, tgt_x, up_x, dn_x;
    logic [2:0] delta;

    always_comb begin
        tgt_in_x = ({1'b0, cmd.cmd_period} < MIN_X) ? MIN_X : {1'b0, cmd.cmd_period};
        start_x  = (START_X > tgt_in_x) ? START_X : tgt_in_x;
        cur_x    = {1'b0, cur_p};
        tgt_x    = {1'b0, target};
        up_x     = cur_x + DEC_X;
        if (up_x > START_X) up_x = START_X;
        dn_x     = (cur_x > DEC_X) ? cur_x - DEC_X : '0;
        if (dn_x < tgt_x) dn_x = tgt_x;
        delta    = mode_q[1] ? 3'd1 : 3'd2;
        sl_dec   = steps_left - ONE_C;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pos_nxt     = position;
        sl_nxt      = steps_left;
        done_nxt    = 1'b0;
        aborted_nxt = aborted;
        dir_nxt     = dir_q;
        mode_nxt    = mode_q;
        target_nxt  = target;
        cur_p_nxt   = cur_p;
        timer_nxt   = timer;
        ramp_nxt    = ramp_cnt;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    dir_nxt     = cmd.cmd_dir;
                    mode_nxt    = cmd.cmd_mode;
                    target_nxt  = tgt_in_x[DIV_W-1:0];
                    cur_p_nxt   = start_x[DIV_W-1:0];
                    timer_nxt   = start_x[DIV_W-1:0];
                    sl_nxt      = cmd.cmd_steps;
                    ramp_nxt    = '0;
                    aborted_nxt = 1'b0;
                    // Snap onto the coil pattern family of the new mode without stepping.
                    if (cmd.cmd_mode == 2'b00)      idx_nxt[0] = 1'b0;
                    else if (cmd.cmd_mode == 2'b01) idx_nxt[0] = 1'b1;
                    if (cmd.cmd_steps == ZERO_C) done_nxt  = 1'b1;
                    else                         state_nxt = RUN;
                end
            end
            RUN: begin
                if (cmd.abort) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (timer <= ONE_P) begin
                    idx_nxt = dir_q ? idx + delta : idx - delta;
                    pos_nxt = dir_q ? position + ONE_POS : position - ONE_POS;
                    sl_nxt  = sl_dec;
                    if (sl_dec <= ramp_cnt && ramp_cnt != ZERO_C) begin
                        cur_p_nxt = up_x[DIV_W-1:0];
                        ramp_nxt  = ramp_cnt - ONE_C;
                    end else if (cur_p > target) begin
                        cur_p_nxt = dn_x[DIV_W-1:0];
                        ramp_nxt  = ramp_cnt + ONE_C;
                    end
                    timer_nxt = cur_p_nxt;
                    if (sl_dec == ZERO_C) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - ONE_P;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            idx        <= '0;
            position   <= '0;
            steps_left <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            dir_q      <= 1'b0;
            mode_q     <= 2'b00;
            target     <= '0;
            cur_p      <= '0;
            timer      <= '0;
            ramp_cnt   <= '0;
        end else begin
            idx        <= idx_nxt;
            position   <= pos_nxt;
            steps_left <= sl_nxt;
            done       <= done_nxt;
            aborted    <= aborted_nxt;
            dir_q      <= dir_nxt;
            mode_q     <= mode_nxt;
            target     <= target_nxt;
            cur_p      <= cur_p_nxt;
            timer      <= timer_nxt;
            ramp_cnt   <= ramp_nxt;
        end
    end

    logic [3:0] pat;
    always_comb begin
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
    end

    assign busy          = (state == RUN);
    assign cmd.cmd_ready = (state == IDLE);
    assign phase         = (state == RUN || HOLD_EN) ? pat : 4'b0000;

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Scoreboarded bench for stepper_axis_ctrl with a fast ramp (16 start, 4 per step).
module tb_stepper_axis_ctrl;
    localparam int CNT_W = 16, DIV_W = 24, POS_W = 16;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic             cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic [DIV_W-1:0] cmd_period = '0;
    logic [1:0]       cmd_mode = 2'b00;

    stepper_axis_ctrl_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) cif ();
    stepper_axis_ctrl_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) cif0 ();
    assign cif.cmd_valid  = cmd_valid;  assign cif0.cmd_valid  = cmd_valid;
    assign cif.cmd_steps  = cmd_steps;  assign cif0.cmd_steps  = cmd_steps;
    assign cif.cmd_dir    = cmd_dir;    assign cif0.cmd_dir    = cmd_dir;
    assign cif.cmd_period = cmd_period; assign cif0.cmd_period = cmd_period;
    assign cif.cmd_mode   = cmd_mode;   assign cif0.cmd_mode   = cmd_mode;
    assign cif.abort      = abort;      assign cif0.abort      = abort;

    logic [3:0]       phase, phase0;
    logic             busy, done, aborted, busy0, done0, aborted0;
    logic [POS_W-1:0] position, position0;
    logic [CNT_W-1:0] steps_left, steps_left0;

    stepper_axis_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W), .START_PERIOD(16),
        .RAMP_DEC(4), .MIN_PERIOD(2), .HOLD_EN(1'b1)) dut (
        .clk_clk(clk), .reset_reset(rst), .cmd(cif), .phase(phase), .busy(busy),
        .done(done), .aborted(aborted), .position(position), .steps_left(steps_left));

    stepper_axis_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W), .START_PERIOD(16),
        .RAMP_DEC(4), .MIN_PERIOD(2), .HOLD_EN(1'b0)) dut0 (
        .clk_clk(clk), .reset_reset(rst), .cmd(cif0), .phase(phase0), .busy(busy0),
        .done(done0), .aborted(aborted0), .position(position0), .steps_left(steps_left0));

    typedef struct {
        logic [3:0]       ph;
        logic [POS_W-1:0] pos;
        int               gap;
    } step_t;
    step_t sb[$];

    int n_chk = 0, n_pass = 0;

    task automatic push(input logic [3:0] ph, input logic [POS_W-1:0] pos, input int gap);
        step_t e;
        e.ph = ph; e.pos = pos; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Returns at the negedge right after the accepting posedge.
    task automatic send(input int steps, input logic dir, input int period, input logic [1:0] mode);
        @(negedge clk);
        cmd_steps = CNT_W'(steps); cmd_dir = dir; cmd_period = DIV_W'(period); cmd_mode = mode;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Pops one expectation per observed step; gap is clocks since the previous step (or accept).
    task automatic drain(input string tag, input int budget);
        int cyc = 0, last = 0, dones = 0;
        logic [POS_W-1:0] lp;
        step_t e;
        lp = position;
        while ((sb.size() > 0 || busy) && cyc < budget) begin
            @(negedge clk); cyc++;
            if (done) dones++;
            if (position !== lp) begin
                lp = position;
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL %s extra_step: got pos=%h phase=%b, required no step", tag, position, phase);
                end else begin
                    e = sb.pop_front();
                    if (phase !== e.ph || position !== e.pos || (cyc - last) != e.gap)
                        $display("FAIL %s step: got phase=%b pos=%h gap=%0d, required phase=%b pos=%h gap=%0d",
                                 tag, phase, position, cyc - last, e.ph, e.pos, e.gap);
                    else n_pass++;
                    last = cyc;
                end
            end
        end
        n_chk++;
        if (sb.size() != 0 || busy) begin
            $display("FAIL %s timeout: got %0d pending busy=%b, required 0 pending busy=0", tag, sb.size(), busy);
            sb.delete();
        end else n_pass++;
        repeat (3) begin @(negedge clk); if (done) dones++; end
        n_chk++;
        if (dones != 1) $display("FAIL %s done_pulses: got %0d, required 1", tag, dones);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({phase, busy, done, aborted, cif.cmd_ready} !== {4'b1000, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_ctl: got phase=%b busy=%b done=%b ab=%b rdy=%b, required 1000 0 0 0 1",
                     phase, busy, done, aborted, cif.cmd_ready);
        else n_pass++;
        n_chk++;
        if (position !== 16'h0 || steps_left !== 16'h0)
            $display("FAIL reset_cnt: got pos=%h sl=%h, required 0 0", position, steps_left);
        else n_pass++;
        n_chk++;
        if (phase0 !== 4'b0000) $display("FAIL reset_nohold_phase: got %b, required 0000", phase0);
        else n_pass++;
    endtask

    task automatic test_half();
        do_reset();
        push(4'b1100, 16'd1, 16); push(4'b0100, 16'd2, 16);
        push(4'b0110, 16'd3, 16); push(4'b0010, 16'd4, 16);
        send(4, 1'b1, 16, 2'b10);
        drain("half", 200);
        n_chk++;
        if (position !== 16'd4 || busy !== 1'b0 || steps_left !== 16'd0)
            $display("FAIL half_end: got pos=%0d busy=%b sl=%0d, required 4 0 0", position, busy, steps_left);
        else n_pass++;
    endtask

    task automatic test_full_ramp();
        do_reset();
        push(4'b0110, 16'd1, 16); push(4'b0011, 16'd2, 12); push(4'b1001, 16'd3, 8);
        push(4'b1100, 16'd4, 8);  push(4'b0110, 16'd5, 12); push(4'b0011, 16'd6, 16);
        send(6, 1'b1, 8, 2'b01);
        n_chk++;
        if (phase !== 4'b1100) $display("FAIL full_align: got %b, required 1100", phase);
        else n_pass++;
        drain("full", 200);
        n_chk++;
        if (position !== 16'd6) $display("FAIL full_pos: got %0d, required 6", position);
        else n_pass++;
    endtask

    task automatic test_wave_rev();
        do_reset();
        push(4'b0001, 16'hFFFF, 16); push(4'b0010, 16'hFFFE, 16); push(4'b0100, 16'hFFFD, 16);
        send(3, 1'b0, 16, 2'b00);
        drain("wave", 200);
        n_chk++;
        if (position !== 16'hFFFD) $display("FAIL wave_pos: got %h, required fffd", position);
        else n_pass++;
    endtask

    task automatic test_abort();
        int cyc = 0;
        do_reset();
        send(100, 1'b1, 16, 2'b10);
        while (steps_left !== 16'd95 && cyc < 300) begin @(negedge clk); cyc++; end
        n_chk++;
        if (steps_left !== 16'd95 || position !== 16'd5 || phase !== 4'b0011)
            $display("FAIL abort_pre: got sl=%0d pos=%0d phase=%b, required 95 5 0011", steps_left, position, phase);
        else n_pass++;
        repeat (15) @(negedge clk);
        abort = 1'b1;            // lands on the edge where the 6th step would fire
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (steps_left !== 16'd95 || position !== 16'd5 || busy !== 1'b0 || done !== 1'b1 || aborted !== 1'b1)
            $display("FAIL abort_end: got sl=%0d pos=%0d busy=%b done=%b ab=%b, required 95 5 0 1 1",
                     steps_left, position, busy, done, aborted);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || aborted !== 1'b1 || phase !== 4'b0011 || phase0 !== 4'b0000)
            $display("FAIL abort_hold: got done=%b ab=%b phase=%b phase0=%b, required 0 1 0011 0000",
                     done, aborted, phase, phase0);
        else n_pass++;
        abort = 1'b1;            // abort while idle must be ignored
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_idle: got done=%b busy=%b, required 0 0", done, busy);
        else n_pass++;
        // zero-step move: clears aborted, done at T+1, never busy
        send(0, 1'b1, 16, 2'b10);
        n_chk++;
        if (aborted !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || cif.cmd_ready !== 1'b1)
            $display("FAIL zero_steps: got ab=%b done=%b busy=%b rdy=%b, required 0 1 0 1",
                     aborted, done, busy, cif.cmd_ready);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_after: got done=%b busy=%b, required 0 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_clamp();
        do_reset();
        push(4'b1100, 16'd1, 16); push(4'b0100, 16'd2, 12); push(4'b0110, 16'd3, 8);
        push(4'b0010, 16'd4, 4);  push(4'b0011, 16'd5, 2);  push(4'b0001, 16'd6, 6);
        push(4'b1001, 16'd7, 10); push(4'b1000, 16'd8, 14);
        send(8, 1'b1, 1, 2'b11);
        drain("clamp", 300);
    endtask

    task automatic test_busy_ignore();
        do_reset();
        send(100, 1'b1, 16, 2'b10);
        repeat (3) @(negedge clk);
        cmd_steps = 16'd7; cmd_dir = 1'b0; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++;
        if (steps_left !== 16'd100 || busy !== 1'b1 || cif.cmd_ready !== 1'b0)
            $display("FAIL busy_ignore: got sl=%0d busy=%b rdy=%b, required 100 1 0", steps_left, busy, cif.cmd_ready);
        else n_pass++;
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(100, 1'b1, 16, 2'b10);
        repeat (40) @(negedge clk);
        n_chk++;
        if (position !== 16'd2 || busy !== 1'b1 || phase0 !== phase || position0 !== 16'd2)
            $display("FAIL mid_pre: got pos=%0d busy=%b phase=%b phase0=%b pos0=%0d, required 2 1 equal 2",
                     position, busy, phase, phase0, position0);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({phase, busy, done, aborted, cif.cmd_ready} !== {4'b1000, 1'b0, 1'b0, 1'b0, 1'b1} ||
            position !== 16'h0 || steps_left !== 16'h0)
            $display("FAIL mid_reset: got phase=%b busy=%b done=%b ab=%b rdy=%b pos=%h sl=%h, required 1000 0 0 0 1 0 0",
                     phase, busy, done, aborted, cif.cmd_ready, position, steps_left);
        else n_pass++;
        n_chk++;
        if (phase0 !== 4'b0000 || busy0 !== 1'b0 || steps_left0 !== 16'h0 || done0 !== 1'b0 || aborted0 !== 1'b0)
            $display("FAIL mid_reset_nohold: got phase0=%b busy0=%b sl0=%h, required 0000 0 0", phase0, busy0, steps_left0);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_half();
        test_full_ramp();
        test_wave_rev();
        test_abort();
        test_clamp();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stepper_axis_ctrl.md
Name: stepper_axis_ctrl

Overview:
- Single-axis stepper motor sequencer with command handshake, linear acceleration/deceleration ramp and selectable wave/full/half stepping.
- Drives the 4 coil lines of one motor and keeps a signed position count.
- Parametrised successor to the fixed-function motor core of the StepperMotorControl system.
- Instantiated once per axis; the CPU bridge writes commands to it and reads position and status back.

Parameters:
- CNT_W, 16: width of step-count command and steps_left.
- DIV_W, 24: width of period (clocks per step) values.
- POS_W, 16: width of the signed position counter.
- START_PERIOD, 50000: ramp start/end period in clocks.
- RAMP_DEC, 2000: period change per step while ramping.
- MIN_PERIOD, 2: lower clamp for the commanded period.
- HOLD_EN, 1: 1 = coils stay energised while idle; 0 = phase forced to 0000 while idle.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  high in IDLE; a command is accepted on cmd_valid & cmd_ready.
- cmd_steps  in  CNT_W  number of steps to move.
- cmd_dir  in  1  1 = forward (+1 per step), 0 = reverse.
- cmd_period  in  DIV_W  target cruise period in clocks.
- cmd_mode  in  2  00 = wave, 01 = full, 10/11 = half.
- abort  in  1  stop the current move.
- phase  out  4  coil drive {A,B,A',B'}.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse at move end (normal end or abort).
- aborted  out  1  sticky; set by abort, cleared on the next command accept.
- position  out  POS_W  signed step position.
- steps_left  out  CNT_W  remaining steps.

Behaviour:
- Reset (async, immediate, also mid-move):
  - state IDLE, idx = 0, position = 0, steps_left = 0, busy = 0, done = 0, aborted = 0, cmd_ready = 1.
  - phase = 1000 if HOLD_EN, else 0000.
- Phase table indexed by idx[2:0]:
  - 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
- States: IDLE, RUN.
- Command accept (IDLE, cmd_valid at edge T):
  - Latch dir, mode and target = max(cmd_period, MIN_PERIOD).
  - steps_left = cmd_steps; aborted = 0; ramp_cnt = 0.
  - cur_p = max(START_PERIOD, target); timer = cur_p.
  - Align idx without stepping: full sets idx[0] = 1, wave clears idx[0], half leaves idx unchanged.
  - If cmd_steps = 0: stay IDLE and pulse done at T+1.
  - Otherwise: RUN, with busy = 1 and cmd_ready = 0 from T+1.
- Commands offered while busy are ignored, since cmd_ready is 0.
- RUN:
  - timer decrements every clock.
  - When timer = 1, a step fires on that edge:
    - idx advances ±1 (half) or ±2 (full/wave), modulo 8.
    - position ±1, wrapping modulo 2^POS_W.
    - steps_left −1.
    - timer reloads with the updated cur_p.
  - First step fires cur_p clocks after accept.
- Ramp update at each step, using the post-decrement steps_left:
  - Decel is checked first: if steps_left <= ramp_cnt and ramp_cnt > 0, then cur_p = min(cur_p + RAMP_DEC, START_PERIOD) and ramp_cnt −1.
  - Else accel: if cur_p > target, then cur_p = max(cur_p − RAMP_DEC, target) and ramp_cnt +1.
  - Else cur_p is unchanged.
- Ramp arithmetic is DIV_W+1 wide internally, so it never underflows or overflows.
- Last step (steps_left becomes 0): on the same edge go to IDLE with busy = 0; done = 1 for exactly the next cycle.
- Abort:
  - Sampled in RUN; next edge goes to IDLE and sets done pulse and aborted = 1.
  - steps_left and position hold their values.
  - If a step would fire on the same edge, abort wins and no step is taken.
  - Abort in IDLE is ignored.
- Idle phase: the last idx pattern if HOLD_EN, else 0000. During RUN, phase always reflects idx.

Test Plan:
Bench parameters for all scenarios: START_PERIOD=16, RAMP_DEC=4, MIN_PERIOD=2.
1. Half mode, steps=4, dir=1, period=16 from reset → phase 1100, 0100, 0110, 0010 at 16-clock intervals; position=4; single done pulse; busy low afterwards.
2. Full mode, steps=6, dir=1, period=8 → step intervals 16, 12, 8, 8, 12, 16 clocks; phase sequence starts at idx 1 (1100) and advances to 0110; position=6.
3. Wave mode, steps=3, dir=0 from idx 0 → phase 0001, 0010, 0100; position = 0xFFFD (−3).
4. Half mode, steps=100, period=16; abort asserted after step 5 (including the cycle where timer=1) → no 6th step; steps_left=95; done pulse; aborted=1, which clears on the next accept.
5. steps=0 → done at T+1 and busy never high; period=1 → clamped to 2; cmd_valid while busy → no effect on steps_left.
6. Reset asserted mid-move → all outputs at their reset values immediately (asynchronously); with HOLD_EN=0 the bench sees phase=0000.
